// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// registers the PC/instruction/branch-offset triple for the IF/ID register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | request addr_q; accept response to outputs or skid
// S_HOLD  | skid holds a response captured under stall; no request
// S_DROP  | stale request from before a redirect; discard its response
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        hazard_i,
  input  logic        flush_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [11:0] pc_offset_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic        skid_full_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;
  logic [11:0] offset_q;
  logic        valid_q;

  logic        outstanding;
  logic [31:0] target;
  logic [31:0] addr_next;

  assign imem_req_o  = (state_q != S_HOLD);
  assign imem_addr_o = addr_q;
  assign outstanding = imem_req_o && !imem_rvalid_i;
  assign target      = {br_target_i[31:2], 2'b00};
  assign addr_next   = addr_q + 32'd4;

  assign pc_o        = pc_out_q;
  assign instr_o     = instr_q;
  assign pc_offset_o = offset_q;
  assign valid_o     = valid_q;

  function automatic logic [11:0] offset_of(input logic [31:0] i);
    return {i[31], i[7], i[30:25], i[11:8]};
  endfunction

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_full_q  <= 1'b0;
      pc_out_q     <= 32'h0;
      instr_q      <= 32'h0;
      offset_q     <= 12'h0;
      valid_q      <= 1'b0;
    end else if (flush_i) begin
      pc_q        <= target;
      skid_full_q <= 1'b0;
      instr_q     <= 32'h0;
      offset_q    <= 12'h0;
      valid_q     <= 1'b0;
      // A request still in flight must be allowed to complete before refetching.
      if (outstanding) begin
        state_q <= S_DROP;
      end else begin
        state_q <= S_FETCH;
        addr_q  <= target;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_rvalid_i) begin
            pc_q   <= addr_next;
            addr_q <= addr_next;
            if (hazard_i) begin
              skid_instr_q <= imem_rdata_i;
              skid_pc_q    <= addr_q;
              skid_full_q  <= 1'b1;
              state_q      <= S_HOLD;
            end else begin
              pc_out_q <= addr_q;
              instr_q  <= imem_rdata_i;
              offset_q <= offset_of(imem_rdata_i);
              valid_q  <= 1'b1;
            end
          end else if (!hazard_i) begin
            instr_q  <= 32'h0;
            offset_q <= 12'h0;
            valid_q  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!hazard_i && skid_full_q) begin
            pc_out_q    <= skid_pc_q;
            instr_q     <= skid_instr_q;
            offset_q    <= offset_of(skid_instr_q);
            valid_q     <= 1'b1;
            skid_full_q <= 1'b0;
            state_q     <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) begin
            addr_q  <= pc_q;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
